// File: rtl/jtag_dpi_ctrl_if.sv
// Command/response handshake bundle between the host command source and jtag_dpi_ctrl.
interface jtag_dpi_ctrl_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] cmd_data_i;
  logic       rsp_valid_o;
  logic       rsp_tdo_o;

  // Host side: issues commands, consumes TDO responses.
  modport master (
    output cmd_valid_i,
    output cmd_data_i,
    input  cmd_ready_o,
    input  rsp_valid_o,
    input  rsp_tdo_o
  );

  // Driver side: accepts commands, returns TDO responses.
  modport slave (
    input  cmd_valid_i,
    input  cmd_data_i,
    output cmd_ready_o,
    output rsp_valid_o,
    output rsp_tdo_o
  );
endinterface

// File: rtl/jtag_dpi_ctrl.sv
// Paced JTAG bit-bang driver: each accepted command sets TCK/TMS/TDI/TRSTn and holds
// them for max(TIMEOUT_COUNT,1) clocks, then optionally returns a TDO sample.
// Optional: define JTAG_DPI_TAP_MONITOR_EN to add tap_state_o and a 16-state TAP tracker.
module jtag_dpi_ctrl #(
  parameter logic [5:0] TIMEOUT_COUNT = 6'd10
) (
  input  logic                 clk_i,
  input  logic                 enable_i,
  jtag_dpi_ctrl_if.slave       bus,
  output logic                 tck_o,
  output logic                 tms_o,
  output logic                 tdi_o,
  output logic                 trst_o,
  input  logic                 tdo_i
`ifdef JTAG_DPI_TAP_MONITOR_EN
  ,
  output logic [3:0]           tap_state_o
`endif
);

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned BIT_TCK  = 0;
  localparam int unsigned BIT_TMS  = 1;
  localparam int unsigned BIT_TDI  = 2;
  localparam int unsigned BIT_TRST = 3;
  localparam int unsigned BIT_READ = 4;
  // A zero timeout still holds for one cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL =
    (TIMEOUT_COUNT == 6'd0) ? CNT_W'(0) : CNT_W'(TIMEOUT_COUNT - 6'd1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             read_q, read_d;
  logic             tck_q, tck_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;
  logic             trst_q, trst_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_tdo_q, rsp_tdo_d;
  logic             accept_c;
  logic             unused_reserved;

  assign unused_reserved = ^bus.cmd_data_i[7:5];

  // Next-state, pin and response logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    read_d      = read_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_d      = trst_q;
    rsp_valid_d = 1'b0;
    rsp_tdo_d   = 1'b0;
    accept_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.cmd_valid_i && ready_q) begin
          accept_c = 1'b1;
          tck_d    = bus.cmd_data_i[BIT_TCK];
          tms_d    = bus.cmd_data_i[BIT_TMS];
          tdi_d    = bus.cmd_data_i[BIT_TDI];
          trst_d   = ~bus.cmd_data_i[BIT_TRST];
          read_d   = bus.cmd_data_i[BIT_READ];
          cnt_d    = LOAD_VAL;
          ready_d  = 1'b0;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(0)) begin
          rsp_valid_d = read_q;
          rsp_tdo_d   = read_q & tdo_i;
          read_d      = 1'b0;
          ready_d     = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset parks the TAP in reset with TMS high.
  always_ff @(posedge clk_i or negedge enable_i) begin
    if (!enable_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      read_q      <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      read_q      <= read_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= trst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
    end
  end

  assign bus.cmd_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_tdo_o   = rsp_tdo_q;
  assign tck_o           = tck_q;
  assign tms_o           = tms_q;
  assign tdi_o           = tdi_q;
  assign trst_o          = trst_q;

`ifdef JTAG_DPI_TAP_MONITOR_EN
  typedef enum logic [3:0] {
    TAP_TLR = 4'd0,  TAP_RTI = 4'd1,  TAP_SELDR = 4'd2,  TAP_CAPDR = 4'd3,
    TAP_SHDR = 4'd4, TAP_EX1DR = 4'd5, TAP_PADR = 4'd6,  TAP_EX2DR = 4'd7,
    TAP_UPDR = 4'd8, TAP_SELIR = 4'd9, TAP_CAPIR = 4'd10, TAP_SHIR = 4'd11,
    TAP_EX1IR = 4'd12, TAP_PAIR = 4'd13, TAP_EX2IR = 4'd14, TAP_UPIR = 4'd15
  } tap_e;

  tap_e tap_q, tap_d;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    tap_e n;
    case (s)
      TAP_TLR:   n = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: n = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: n = tms ? TAP_UPDR  : TAP_PADR;
      TAP_PADR:  n = tms ? TAP_EX2DR : TAP_PADR;
      TAP_EX2DR: n = tms ? TAP_UPDR  : TAP_SHDR;
      TAP_UPDR:  n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: n = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: n = tms ? TAP_UPIR  : TAP_PAIR;
      TAP_PAIR:  n = tms ? TAP_EX2IR : TAP_PAIR;
      TAP_EX2IR: n = tms ? TAP_UPIR  : TAP_SHIR;
      default:   n = tms ? TAP_SELDR : TAP_RTI;
    endcase
    return n;
  endfunction

  // Advance on a commanded TCK rising edge; TRSTn low forces Test-Logic-Reset.
  always_comb begin
    tap_d = tap_q;
    if (!trst_d) begin
      tap_d = TAP_TLR;
    end else if (accept_c && !tck_q && tck_d) begin
      tap_d = tap_next(tap_q, tms_d);
    end
  end

  // Tracker register.
  always_ff @(posedge clk_i or negedge enable_i) begin
    if (!enable_i) tap_q <= TAP_TLR;
    else           tap_q <= tap_d;
  end

  assign tap_state_o = tap_q;
`endif

endmodule

// File: tb/tb_jtag_dpi_ctrl.sv
// Randomized self-checking bench for jtag_dpi_ctrl: one instance with a 10-cycle hold
// and one with TIMEOUT_COUNT=0, both checked against a command-level model.
module tb_jtag_dpi_ctrl;
  localparam logic [5:0] TO_A = 6'd10;
  localparam logic [5:0] TO_B = 6'd0;

  // IEEE 1149.1 next-state tables indexed by current state, for TMS=0 and TMS=1.
  localparam logic [3:0] TAP_ON0 [16] = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                                          4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
  localparam logic [3:0] TAP_ON1 [16] = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                                          4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};

  logic       clk = 1'b0;
  logic       enable;
  logic       tdo;
  logic [7:0] data;
  logic       valid_a, valid_b;
  logic       tck_a, tms_a, tdi_a, trst_a;
  logic       tck_b, tms_b, tdi_b, trst_b;
  logic [1:0] rdy, rspv, rspt;
  logic [3:0] pins [2];

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_pins [2];
  logic       prev_tck [2];
  logic [3:0] exp_tap  [2];

  jtag_dpi_ctrl_if if_a ();
  jtag_dpi_ctrl_if if_b ();

  assign if_a.cmd_valid_i = valid_a;
  assign if_a.cmd_data_i  = data;
  assign if_b.cmd_valid_i = valid_b;
  assign if_b.cmd_data_i  = data;
  assign rdy  = {if_b.cmd_ready_o, if_a.cmd_ready_o};
  assign rspv = {if_b.rsp_valid_o, if_a.rsp_valid_o};
  assign rspt = {if_b.rsp_tdo_o, if_a.rsp_tdo_o};
  assign pins[0] = {trst_a, tdi_a, tms_a, tck_a};
  assign pins[1] = {trst_b, tdi_b, tms_b, tck_b};

`ifdef JTAG_DPI_TAP_MONITOR_EN
  logic [3:0] tap_w [2];
`endif

  jtag_dpi_ctrl #(.TIMEOUT_COUNT(TO_A)) dut_a (
    .clk_i(clk), .enable_i(enable), .bus(if_a.slave),
    .tck_o(tck_a), .tms_o(tms_a), .tdi_o(tdi_a), .trst_o(trst_a), .tdo_i(tdo)
`ifdef JTAG_DPI_TAP_MONITOR_EN
    , .tap_state_o(tap_w[0])
`endif
  );

  jtag_dpi_ctrl #(.TIMEOUT_COUNT(TO_B)) dut_b (
    .clk_i(clk), .enable_i(enable), .bus(if_b.slave),
    .tck_o(tck_b), .tms_o(tms_b), .tdi_o(tdi_b), .trst_o(trst_b), .tdo_i(tdo)
`ifdef JTAG_DPI_TAP_MONITOR_EN
    , .tap_state_o(tap_w[1])
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hold_cycles(input int sel);
    int to;
    to = (sel == 0) ? int'(TO_A) : int'(TO_B);
    return (to == 0) ? 1 : to;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_pins[s] = 4'b0010;  // {trst,tdi,tms,tck}: TRSTn low, TMS high
      prev_tck[s] = 1'b0;
      exp_tap[s]  = 4'd0;
    end
  endtask

  task automatic check_tap(input int sel);
`ifdef JTAG_DPI_TAP_MONITOR_EN
    chk("tap_state", 32'(tap_w[sel]), 32'(exp_tap[sel]));
`else
    if (sel < 0) $display("unreachable");
`endif
  endtask

  // Issue one command on instance sel at a negedge and check the whole transaction.
  task automatic send(input int sel, input logic [7:0] d, input logic t);
    int n;
    int waited;
    n = hold_cycles(sel);
    tdo  = t;
    data = d;
    waited = 0;
    while (!rdy[sel] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_cmd", 32'(rdy[sel]), 32'd1);
    if (sel == 0) valid_a = 1'b1; else valid_b = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    data    = 8'($urandom);
    // Model: pins follow the command; TAP advances on a TCK 0->1 with new TMS.
    exp_pins[sel] = {~d[3], d[2], d[1], d[0]};
    if (d[3]) exp_tap[sel] = 4'd0;
    else if (!prev_tck[sel] && d[0])
      exp_tap[sel] = d[1] ? TAP_ON1[exp_tap[sel]] : TAP_ON0[exp_tap[sel]];
    prev_tck[sel] = d[0];
    chk("pins_after_accept", 32'(pins[sel]), 32'(exp_pins[sel]));
    check_tap(sel);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clk);
      chk("ready_low_hold", 32'(rdy[sel]), 32'd0);
      chk("no_rsp_in_hold", 32'(rspv[sel]), 32'd0);
    end
    @(negedge clk);
    chk("ready_after_hold", 32'(rdy[sel]), 32'd1);
    chk("rsp_valid", 32'(rspv[sel]), 32'(d[4]));
    if (d[4]) chk("rsp_tdo", 32'(rspt[sel]), 32'(t));
    chk("pins_held", 32'(pins[sel]), 32'(exp_pins[sel]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  sel;
    bit  seen;
    enable  = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    tdo     = 1'b0;
    data    = 8'h00;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_pins", 32'(pins[s]), 32'b0010);
      chk("reset_ready", 32'(rdy[s]), 32'd0);
      chk("reset_rsp", 32'(rspv[s]), 32'd0);
      check_tap(s);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("ready_after_release_a", 32'(rdy[0]), 32'd1);
    chk("ready_after_release_b", 32'(rdy[1]), 32'd1);

    // Pacing, readback and TRST.
    send(0, 8'h05, 1'b0);
    send(0, 8'h10, 1'b1);
    send(0, 8'h10, 1'b0);
    send(0, 8'h08, 1'b1);
    chk("trst_asserted", 32'(trst_a), 32'd0);
    send(0, 8'h00, 1'b1);
    chk("trst_released", 32'(trst_a), 32'd1);

    // TAP walk to Shift-DR then Exit1-DR, with a TCK low/high pair per TMS value.
    begin
      logic [8:0] walk;
      walk = 9'b001011111;  // TMS 1,1,1,1,1,0,1,0,0 taken LSB first
      for (int i = 0; i < 9; i++) begin
        send(0, {6'd0, walk[i], 1'b0}, 1'b0);
        send(0, {6'd0, walk[i], 1'b1}, 1'b0);
      end
`ifdef JTAG_DPI_TAP_MONITOR_EN
      chk("tap_shdr", 32'(tap_w[0]), 32'd4);
`endif
      send(0, 8'h02, 1'b0);
      send(0, 8'h03, 1'b0);
`ifdef JTAG_DPI_TAP_MONITOR_EN
      chk("tap_ex1dr", 32'(tap_w[0]), 32'd5);
`endif
    end

    // TIMEOUT_COUNT=0 instance: one-cycle hold, back-to-back commands.
    send(1, 8'h15, 1'b1);
    send(1, 8'h10, 1'b0);
    send(1, 8'h08, 1'b1);

    // Randomized commands on both instances with idle gaps.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2) == 0);
      send(sel, 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("pins_idle", 32'(pins[sel]), 32'(exp_pins[sel]));
    end

    // Reset in the middle of a hold with a read pending.
    send(0, 8'h00, 1'b0);
    tdo     = 1'b1;
    data    = 8'h17;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    chk("midhold_pins_before", 32'(pins[0]), 32'b1111);
    repeat (3) @(negedge clk);
    #1 enable = 1'b0;
    #1;
    model_reset();
    chk("midhold_pins_reset", 32'(pins[0]), 32'(exp_pins[0]));
    chk("midhold_ready_reset", 32'(rdy[0]), 32'd0);
    chk("midhold_rsp_reset", 32'(rspv[0]), 32'd0);
    check_tap(0);
    @(negedge clk);
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rspv[0]) seen = 1'b1;
    end
    chk("midhold_rsp_dropped", 32'(seen), 32'd0);
    chk("midhold_ready_back", 32'(rdy[0]), 32'd1);
    chk("midhold_pins_stay", 32'(pins[0]), 32'b0010);
    send(0, 8'h1c, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
